// File: rtl/controle_pipeline_pkg.sv
// ============================================================================
// controle_pipeline_pkg
//   Shared state encodings, pipeline-control bundle and constants.
//   Revision: 1.0
// ============================================================================
`default_nettype none

package controle_pipeline_pkg;

  localparam int REG_IDX_W = 5;
  localparam int OPCODE_W  = 6;
  localparam logic [OPCODE_W-1:0] HALT_OPCODE_DEF = 6'h3F;

  typedef enum logic [2:0] {
    ST_FILL     = 3'd0,
    ST_RUN      = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_HALT     = 3'd4
  } estado_t;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic pipe_write;
    logic hazard_mux;
    logic flush_ifid;
    logic flush_idex;
    logic flush_exmem;
    logic suppress_wb;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET  = '{pc_write: 1'b0, ifid_write: 1'b0, pipe_write: 1'b0, hazard_mux: 1'b1,
                                    flush_ifid: 1'b0, flush_idex: 1'b0, flush_exmem: 1'b0, suppress_wb: 1'b1};
  localparam ctrl_t CTRL_FILL   = '{pc_write: 1'b1, ifid_write: 1'b1, pipe_write: 1'b1, hazard_mux: 1'b0,
                                    flush_ifid: 1'b0, flush_idex: 1'b0, flush_exmem: 1'b0, suppress_wb: 1'b1};
  localparam ctrl_t CTRL_RUN    = '{pc_write: 1'b1, ifid_write: 1'b1, pipe_write: 1'b1, hazard_mux: 1'b0,
                                    flush_ifid: 1'b0, flush_idex: 1'b0, flush_exmem: 1'b0, suppress_wb: 1'b0};
  localparam ctrl_t CTRL_BRANCH = '{pc_write: 1'b1, ifid_write: 1'b1, pipe_write: 1'b1, hazard_mux: 1'b0,
                                    flush_ifid: 1'b1, flush_idex: 1'b1, flush_exmem: 1'b1, suppress_wb: 1'b0};
  localparam ctrl_t CTRL_BUBBLE = '{pc_write: 1'b0, ifid_write: 1'b0, pipe_write: 1'b1, hazard_mux: 1'b1,
                                    flush_ifid: 1'b0, flush_idex: 1'b0, flush_exmem: 1'b0, suppress_wb: 1'b0};
  localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, pipe_write: 1'b0, hazard_mux: 1'b0,
                                    flush_ifid: 1'b0, flush_idex: 1'b0, flush_exmem: 1'b0, suppress_wb: 1'b0};
  localparam ctrl_t CTRL_HALT   = '{pc_write: 1'b0, ifid_write: 1'b0, pipe_write: 1'b0, hazard_mux: 1'b1,
                                    flush_ifid: 1'b0, flush_idex: 1'b0, flush_exmem: 1'b0, suppress_wb: 1'b1};

endpackage

`default_nettype wire

// File: rtl/controle_pipeline_deteccao_load_use.sv
// ============================================================================
// deteccao_load_use
//   Combinational load-use hazard compare between ID/EX load and IF/ID sources.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module deteccao_load_use
  import controle_pipeline_pkg::*;
(
  input  logic                 idex_mem_read,
  input  logic [REG_IDX_W-1:0] idex_rt,
  input  logic [REG_IDX_W-1:0] ifid_rs,
  input  logic [REG_IDX_W-1:0] ifid_rt,
  output logic                 load_use
);

  // Register 0 is hardwired, so a load targeting it can never create a hazard.
  assign load_use = idex_mem_read && (idex_rt != '0) &&
                    ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

`default_nettype wire

// File: rtl/controle_pipeline.sv
// ============================================================================
// controle_pipeline
//   Pipeline sequencing FSM: fill gating, load-use stall, branch flush,
//   memory-wait freeze and halt drain.  Revision: 1.0
// ============================================================================
`default_nettype none

module controle_pipeline
  import controle_pipeline_pkg::*;
#(
  parameter int                  FILL_CYCLES = 4,
  parameter int                  MEM_TIMEOUT = 255,
  parameter logic [OPCODE_W-1:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [OPCODE_W-1:0]  IFID_opcode,
  input  logic [REG_IDX_W-1:0] IFID_rs,
  input  logic [REG_IDX_W-1:0] IFID_rt,
  input  logic                 IDEX_memRead,
  input  logic [REG_IDX_W-1:0] IDEX_rt,
  input  logic                 PCSrc,
  input  logic                 memBusy,
  output logic                 PCWrite,
  output logic                 IFIDWrite,
  output logic                 pipeWrite,
  output logic                 hazardMux,
  output logic                 flushIFID,
  output logic                 flushIDEX,
  output logic                 flushEXMEM,
  output logic                 suppressWB,
  output logic                 halted,
  output logic                 erro,
  output logic [2:0]           estado,
  output logic [15:0]          stallCount
);

  localparam int FILL_W = $clog2(FILL_CYCLES + 1);
  localparam int TO_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FILL_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(MEM_TIMEOUT - 1);

  estado_t           state_q, state_d, run_next;
  logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [TO_W-1:0]   busy_cnt_q, busy_cnt_d;
  logic [1:0]        drain_cnt_q, drain_cnt_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;
  logic              erro_q, erro_d;
  logic              lu;
  ctrl_t             run_ctrl, ctrl, ctrl_out;

  deteccao_load_use u_lu (
    .idex_mem_read (IDEX_memRead),
    .idex_rt       (IDEX_rt),
    .ifid_rs       (IFID_rs),
    .ifid_rt       (IFID_rt),
    .load_use      (lu)
  );

  // Steady-state decisions, shared by RUN and the cycle MEM_WAIT releases.
  always_comb begin
    run_ctrl = CTRL_RUN;
    run_next = ST_RUN;
    if (PCSrc) begin
      run_ctrl = CTRL_BRANCH;
    end else if (lu) begin
      run_ctrl = CTRL_BUBBLE;
    end else if (IFID_opcode == HALT_OPCODE) begin
      run_ctrl = CTRL_BUBBLE;
      run_next = ST_DRAIN;
    end
  end

  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    busy_cnt_d  = busy_cnt_q;
    drain_cnt_d = drain_cnt_q;
    erro_d      = erro_q;
    ctrl        = CTRL_RESET;
    case (state_q)
      ST_FILL: begin
        ctrl = CTRL_FILL;
        if (memBusy) begin
          ctrl.pc_write   = 1'b0;
          ctrl.ifid_write = 1'b0;
          ctrl.pipe_write = 1'b0;
        end else begin
          if (lu) begin
            ctrl.pc_write   = 1'b0;
            ctrl.ifid_write = 1'b0;
            ctrl.hazard_mux = 1'b1;
          end
          if (fill_cnt_q == FILL_LAST) begin
            state_d = ST_RUN;
          end else begin
            fill_cnt_d = fill_cnt_q + FILL_W'(1);
          end
        end
      end
      ST_RUN: begin
        if (memBusy) begin
          ctrl       = CTRL_FREEZE;
          state_d    = ST_MEM_WAIT;
          busy_cnt_d = TO_W'(1);
        end else begin
          ctrl        = run_ctrl;
          state_d     = run_next;
          drain_cnt_d = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (memBusy) begin
          ctrl = CTRL_FREEZE;
          if (busy_cnt_q == TO_LAST) begin
            state_d = ST_HALT;
            erro_d  = 1'b1;
          end else begin
            busy_cnt_d = busy_cnt_q + TO_W'(1);
          end
        end else begin
          ctrl        = run_ctrl;
          state_d     = run_next;
          drain_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        ctrl = CTRL_BUBBLE;
        if (memBusy) begin
          ctrl.pipe_write = 1'b0;
        end else if (PCSrc) begin
          // The halt opcode was fetched down a mispredicted path.
          ctrl    = CTRL_BRANCH;
          state_d = ST_RUN;
        end else if (drain_cnt_q == 2'd2) begin
          state_d = ST_HALT;
        end else begin
          drain_cnt_d = drain_cnt_q + 2'd1;
        end
      end
      ST_HALT: ctrl = CTRL_HALT;
      default: state_d = ST_FILL;
    endcase

    stall_cnt_d = stall_cnt_q;
    if (!ctrl.pc_write && (state_q != ST_HALT) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_FILL;
      fill_cnt_q  <= '0;
      busy_cnt_q  <= '0;
      drain_cnt_q <= '0;
      stall_cnt_q <= '0;
      erro_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      busy_cnt_q  <= busy_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      erro_q      <= erro_d;
    end
  end

  assign ctrl_out   = reset_n ? ctrl : CTRL_RESET;
  assign PCWrite    = ctrl_out.pc_write;
  assign IFIDWrite  = ctrl_out.ifid_write;
  assign pipeWrite  = ctrl_out.pipe_write;
  assign hazardMux  = ctrl_out.hazard_mux;
  assign flushIFID  = ctrl_out.flush_ifid;
  assign flushIDEX  = ctrl_out.flush_idex;
  assign flushEXMEM = ctrl_out.flush_exmem;
  assign suppressWB = ctrl_out.suppress_wb;
  assign halted     = reset_n && (state_q == ST_HALT);
  assign erro       = reset_n && erro_q;
  assign estado     = reset_n ? state_q : ST_FILL;
  assign stallCount = reset_n ? stall_cnt_q : 16'd0;

endmodule

`default_nettype wire

// File: tb/tb_controle_pipeline.sv
// ============================================================================
// tb_controle_pipeline
//   Scoreboard bench: directed scenarios then random traffic vs. a cycle model.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_controle_pipeline;

  localparam int FILL_CYCLES = 4;
  localparam int MEM_TIMEOUT = 255;

  typedef struct packed {
    logic [7:0]  ctrl;   // {pc, ifid, pipe, hazard, flIFID, flIDEX, flEXMEM, supWB}
    logic [7:0]  care;
    logic        halted;
    logic        erro;
    logic [2:0]  estado;
    logic [15:0] stall;
  } exp_t;

  logic        clock, reset_n;
  logic [5:0]  IFID_opcode;
  logic [4:0]  IFID_rs, IFID_rt, IDEX_rt;
  logic        IDEX_memRead, PCSrc, memBusy;
  logic        PCWrite, IFIDWrite, pipeWrite, hazardMux;
  logic        flushIFID, flushIDEX, flushEXMEM, suppressWB, halted, erro;
  logic [2:0]  estado;
  logic [15:0] stallCount;

  controle_pipeline #(.FILL_CYCLES(FILL_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT), .HALT_OPCODE(6'h3F)) dut (
    .clock(clock), .reset_n(reset_n), .IFID_opcode(IFID_opcode), .IFID_rs(IFID_rs),
    .IFID_rt(IFID_rt), .IDEX_memRead(IDEX_memRead), .IDEX_rt(IDEX_rt), .PCSrc(PCSrc),
    .memBusy(memBusy), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .pipeWrite(pipeWrite),
    .hazardMux(hazardMux), .flushIFID(flushIFID), .flushIDEX(flushIDEX),
    .flushEXMEM(flushEXMEM), .suppressWB(suppressWB), .halted(halted), .erro(erro),
    .estado(estado), .stallCount(stallCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  exp_t sb[$];
  int   n_checks = 0, n_errors = 0, n_push = 0, n_pop = 0;

  // Reference model: spec-level mode plus progress counters.
  int m_state = 0, m_fill = 0, m_busy = 0, m_drain = 0, m_stall = 0;
  bit m_erro = 0;

  task automatic step(input logic rst, input logic [5:0] op, input logic [4:0] rs,
                      input logic [4:0] rt, input logic mr, input logic [4:0] xrt,
                      input logic pcs, input logic busy);
    exp_t e;
    logic pc, ifw, pw, hz, fi, fd, fe, sw;
    logic [7:0] care;
    int nxt;
    bit lu;
    reset_n = rst; IFID_opcode = op; IFID_rs = rs; IFID_rt = rt;
    IDEX_memRead = mr; IDEX_rt = xrt; PCSrc = pcs; memBusy = busy;
    care = 8'hFF; fi = 0; fd = 0; fe = 0;
    lu = mr && (xrt != 0) && ((xrt == rs) || (xrt == rt));
    if (!rst) begin
      {pc, ifw, pw, hz, sw} = 5'b00011;
      e.halted = 0; e.erro = 0; e.estado = 0; e.stall = 0;
      m_state = 0; m_fill = 0; m_busy = 0; m_drain = 0; m_stall = 0; m_erro = 0;
    end else begin
      e.halted = (m_state == 4); e.erro = m_erro; e.estado = 3'(m_state); e.stall = 16'(m_stall);
      nxt = m_state;
      pc = 0; ifw = 0; pw = 0; hz = 1; sw = 1;
      if (m_state == 0) begin
        pc = 1; ifw = 1; pw = 1; sw = 1; care[4] = 0;
        if (busy) begin
          pc = 0; ifw = 0; pw = 0;
        end else begin
          if (lu) begin pc = 0; ifw = 0; hz = 1; care[4] = 1; end
          m_fill++;
          if (m_fill == FILL_CYCLES) nxt = 1;
        end
      end else if (m_state == 1 || (m_state == 2 && !busy)) begin
        if (busy) begin
          pc = 0; ifw = 0; pw = 0; care[4] = 0; care[0] = 0; nxt = 2; m_busy = 1;
        end else begin
          pc = 1; ifw = 1; pw = 1; hz = 0; sw = 0; nxt = 1;
          if (pcs) begin fi = 1; fd = 1; fe = 1; end
          else if (lu) begin pc = 0; ifw = 0; hz = 1; end
          else if (op == 6'h3F) begin pc = 0; ifw = 0; hz = 1; nxt = 3; m_drain = 0; end
        end
      end else if (m_state == 2) begin
        pc = 0; ifw = 0; pw = 0; care[4] = 0; care[0] = 0;
        m_busy++;
        if (m_busy == MEM_TIMEOUT) begin nxt = 4; m_erro = 1; end
      end else if (m_state == 3) begin
        pc = 0; ifw = 0; hz = 1; pw = 1; care[0] = 0;
        if (busy) pw = 0;
        else if (pcs) begin fi = 1; fd = 1; fe = 1; pc = 1; care[6] = 0; care[4] = 0; nxt = 1; end
        else begin m_drain++; if (m_drain == 3) nxt = 4; end
      end else begin
        care[4] = 0; care[0] = 0;
      end
      if (!pc && m_state != 4 && m_stall < 65535) m_stall++;
      m_state = nxt;
    end
    e.ctrl = {pc, ifw, pw, hz, fi, fd, fe, sw};
    e.care = care;
    sb.push_back(e);
    n_push++;
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 6'h00, 5'd1, 5'd2, 0, 5'd0, 0, 0);
  endtask

  exp_t mon_e;
  logic [7:0] mon_act;
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_pop++;
      mon_act = {PCWrite, IFIDWrite, pipeWrite, hazardMux, flushIFID, flushIDEX, flushEXMEM, suppressWB};
      n_checks++;
      if (((mon_act ^ mon_e.ctrl) & mon_e.care) != 8'h00) begin
        n_errors++;
        $display("FAIL ctrl t=%0t got=%b want=%b care=%b", $time, mon_act, mon_e.ctrl, mon_e.care);
      end
      n_checks++;
      if ({halted, erro, estado} != {mon_e.halted, mon_e.erro, mon_e.estado}) begin
        n_errors++;
        $display("FAIL status t=%0t got halted=%b erro=%b estado=%0d want halted=%b erro=%b estado=%0d",
                 $time, halted, erro, estado, mon_e.halted, mon_e.erro, mon_e.estado);
      end
      n_checks++;
      if (stallCount != mon_e.stall) begin
        n_errors++;
        $display("FAIL stallCount t=%0t got=%0d want=%0d", $time, stallCount, mon_e.stall);
      end
    end
  end

  initial begin
    int busy_left, halt_cycles;
    logic r, pcs, mr, busy;
    logic [5:0] op;
    reset_n = 0; IFID_opcode = 0; IFID_rs = 0; IFID_rt = 0;
    IDEX_memRead = 0; IDEX_rt = 0; PCSrc = 0; memBusy = 0;
    @(posedge clock); #1;

    // Reset, fill, load-use, register-0 load, branch over a load-use.
    step(0, 6'h00, 5'd0, 5'd0, 0, 5'd0, 0, 0);
    idle(6);
    step(1, 6'h00, 5'd5, 5'd3, 1, 5'd5, 0, 0);
    step(1, 6'h00, 5'd5, 5'd3, 0, 5'd5, 0, 0);
    step(1, 6'h00, 5'd0, 5'd0, 1, 5'd0, 0, 0);
    step(1, 6'h00, 5'd5, 5'd3, 1, 5'd5, 1, 0);
    idle(1);
    // Memory wait with a branch resolving during the freeze.
    step(1, 6'h00, 5'd1, 5'd2, 0, 5'd0, 0, 1);
    step(1, 6'h00, 5'd1, 5'd2, 0, 5'd0, 1, 1);
    step(1, 6'h00, 5'd1, 5'd2, 0, 5'd0, 1, 1);
    step(1, 6'h00, 5'd1, 5'd2, 0, 5'd0, 1, 0);
    idle(2);
    // Halt drain to completion, then a wrong-path halt cancelled by a branch.
    step(1, 6'h3F, 5'd1, 5'd2, 0, 5'd0, 0, 0);
    idle(5);
    step(0, 6'h00, 5'd0, 5'd0, 0, 5'd0, 0, 0);
    idle(6);
    step(1, 6'h3F, 5'd1, 5'd2, 0, 5'd0, 0, 0);
    idle(1);
    step(1, 6'h00, 5'd1, 5'd2, 0, 5'd0, 1, 0);
    idle(3);
    // Memory timeout, then reset while halted.
    for (int i = 0; i < MEM_TIMEOUT + 1; i++) step(1, 6'h00, 5'd1, 5'd2, 0, 5'd0, 0, 1);
    idle(2);
    step(0, 6'h00, 5'd0, 5'd0, 0, 5'd0, 0, 0);
    idle(6);

    busy_left = 0; halt_cycles = 0;
    for (int i = 0; i < 4000; i++) begin
      halt_cycles = (m_state == 4) ? halt_cycles + 1 : 0;
      r = ($urandom_range(0, 299) != 0) && (halt_cycles < 4);
      if (busy_left == 0) begin
        if ($urandom_range(0, 599) == 0) busy_left = $urandom_range(250, 262);
        else if ($urandom_range(0, 11) == 0) busy_left = $urandom_range(1, 6);
      end
      busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      pcs = ($urandom_range(0, 7) == 0);
      mr = ($urandom_range(0, 2) == 0);
      op = ($urandom_range(0, 24) == 0) ? 6'h3F : 6'($urandom_range(0, 62));
      step(r, op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), mr,
           5'($urandom_range(0, 7)), pcs, busy);
    end

    repeat (3) @(negedge clock);
    n_checks++;
    if (sb.size() != 0 || n_pop != n_push) begin
      n_errors++;
      $display("FAIL scoreboard_drain got popped=%0d left=%0d want popped=%0d left=0", n_pop, sb.size(), n_push);
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
